// File: rtl/dm_codec_chain.sv
// dm_codec_chain: delta-modulation encoder, mirror decoder and power-of-two
// moving-average filter, each stage qualified by its own valid strobe.
// Optional feature macro: ADAPTIVE_STEP_EN (run-length adaptive step size).
// Pipeline: input register -> encoder -> decoder -> filter, one stage per clock.
module dm_codec_chain #(
  parameter int WIDTH    = 8,
  parameter int STEP     = 1,
  parameter int STEP_MAX = 16,
  parameter int AVG_LOG2 = 2
) (
  input  logic                    CLK100MHZ,
  input  logic                    reset,
  input  logic                    start,
  input  logic signed [WIDTH-1:0] sample_in,
  input  logic                    sample_valid,
  output logic                    encoded_bit,
  output logic                    encoded_valid,
  output logic signed [WIDTH-1:0] decode_out,
  output logic                    decode_valid,
  output logic signed [WIDTH-1:0] filtered,
  output logic                    filtered_valid,
  output logic                    busy
);

  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int SUM_W = WIDTH + AVG_LOG2;
  localparam logic [WIDTH-1:0] STEP_INIT = WIDTH'(STEP);
  localparam logic signed [WIDTH+1:0] ACC_MAX = (WIDTH+2)'((1 << (WIDTH-1)) - 1);
  localparam logic signed [WIDTH+1:0] ACC_MIN = -ACC_MAX - 1;
  localparam logic [AVG_LOG2:0] FILL_FULL = (AVG_LOG2+1)'(DEPTH);

  // Reject parameter sets the datapath cannot represent (elaboration only).
  if (STEP < 1 || STEP >= (1 << (WIDTH-1)) || STEP_MAX < STEP || AVG_LOG2 < 1) begin : g_param_check
    $error("dm_codec_chain: illegal parameter combination");
  end

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t state;
  state_t state_next;
  logic   accept;

  // Stage 0: registered sample
  logic signed [WIDTH-1:0] s_data;
  logic                    s_valid;

  // Encoder internals
  logic signed [WIDTH-1:0] acc_e;
  logic                    enc_bit;
  logic [WIDTH-1:0]        step_e;
  logic [WIDTH-1:0]        step_d;

  // Filter internals
  logic signed [WIDTH-1:0] buffer [DEPTH];
  logic [AVG_LOG2-1:0]     wr_ptr;
  logic [AVG_LOG2:0]       fill;
  logic [AVG_LOG2:0]       fill_next;
  logic signed [SUM_W-1:0] sum;
  logic signed [SUM_W-1:0] sum_next;

  // Shared accumulator update: add or subtract the step, clamp instead of wrapping.
  function automatic logic signed [WIDTH-1:0] acc_update(
    input logic signed [WIDTH-1:0] acc,
    input logic [WIDTH-1:0]        step,
    input logic                    up
  );
    logic signed [WIDTH+1:0] wide;
    if (up)
      wide = {{2{acc[WIDTH-1]}}, acc} + {2'b00, step};
    else
      wide = {{2{acc[WIDTH-1]}}, acc} - {2'b00, step};
    if (wide > ACC_MAX)
      return WIDTH'(ACC_MAX);
    if (wide < ACC_MIN)
      return WIDTH'(ACC_MIN);
    return wide[WIDTH-1:0];
  endfunction

  // FSM state register
  always_ff @(posedge CLK100MHZ or negedge reset) begin
    if (!reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  // FSM next state; a sample is taken only while already in RUN with start still high
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (start)
          state_next = RUN;
      end
      RUN: begin
        if (!start)
          state_next = IDLE;
        else
          accept = sample_valid;
      end
      default: state_next = IDLE;
    endcase
  end

  // Input register: captures accepted samples so the encoder sees a stable value
  always_ff @(posedge CLK100MHZ or negedge reset) begin
    if (!reset) begin
      s_data  <= '0;
      s_valid <= 1'b0;
    end else begin
      s_valid <= accept;
      if (accept)
        s_data <= sample_in;
    end
  end

  // Encoder decision: strictly greater gives a 1, equality gives a 0
  assign enc_bit = (s_data > acc_e);

  // Encoder: emit the bit and track the reconstruction the decoder will build
  always_ff @(posedge CLK100MHZ or negedge reset) begin
    if (!reset) begin
      encoded_bit   <= 1'b0;
      encoded_valid <= 1'b0;
      acc_e         <= '0;
    end else begin
      encoded_valid <= s_valid;
      if (s_valid) begin
        encoded_bit <= enc_bit;
        acc_e       <= acc_update(acc_e, step_e, enc_bit);
      end
    end
  end

`ifdef ADAPTIVE_STEP_EN
  localparam logic [WIDTH:0] STEP_CAP = (WIDTH+1)'(STEP_MAX);

  logic [1:0] run_e;
  logic [1:0] run_d;
  logic       prev_d;
  logic       same_e;
  logic       same_d;
  logic [1:0] run_e_next;
  logic [1:0] run_d_next;

  // Run length saturates at 3: anything from the third identical bit on doubles the step.
  function automatic logic [1:0] run_update(input logic [1:0] run, input logic same);
    if (!same)
      return 2'd1;
    if (run == 2'd3)
      return 2'd3;
    return run + 2'd1;
  endfunction

  // Step after applying a bit: back to base on a change, doubled (capped) on long runs.
  function automatic logic [WIDTH-1:0] step_update(
    input logic [WIDTH-1:0] step,
    input logic             same,
    input logic [1:0]       run
  );
    logic [WIDTH:0] doubled;
    doubled = {step, 1'b0};
    if (!same)
      return STEP_INIT;
    if (run != 2'd3)
      return step;
    if (doubled > STEP_CAP)
      return WIDTH'(STEP_CAP);
    return doubled[WIDTH-1:0];
  endfunction

  // A zero run length means no bit seen yet, so the first bit never counts as a repeat.
  assign same_e     = (run_e != 2'd0) && (enc_bit == encoded_bit);
  assign same_d     = (run_d != 2'd0) && (encoded_bit == prev_d);
  assign run_e_next = run_update(run_e, same_e);
  assign run_d_next = run_update(run_d, same_d);

  // Encoder step adaptation, advanced once per encoded bit
  always_ff @(posedge CLK100MHZ or negedge reset) begin
    if (!reset) begin
      run_e  <= 2'd0;
      step_e <= STEP_INIT;
    end else if (s_valid) begin
      run_e  <= run_e_next;
      step_e <= step_update(step_e, same_e, run_e_next);
    end
  end

  // Decoder step adaptation, driven only by the received bit stream
  always_ff @(posedge CLK100MHZ or negedge reset) begin
    if (!reset) begin
      run_d  <= 2'd0;
      prev_d <= 1'b0;
      step_d <= STEP_INIT;
    end else if (encoded_valid) begin
      run_d  <= run_d_next;
      prev_d <= encoded_bit;
      step_d <= step_update(step_d, same_d, run_d_next);
    end
  end
`else
  assign step_e = STEP_INIT;
  assign step_d = STEP_INIT;
`endif

  // Decoder: mirror accumulator, so decode_out trails acc_e by exactly one cycle
  always_ff @(posedge CLK100MHZ or negedge reset) begin
    if (!reset) begin
      decode_out   <= '0;
      decode_valid <= 1'b0;
    end else begin
      decode_valid <= encoded_valid;
      if (encoded_valid)
        decode_out <= acc_update(decode_out, step_d, encoded_bit);
    end
  end

  // Filter arithmetic: replace the oldest entry in the running sum
  always_comb begin
    sum_next  = sum + SUM_W'(decode_out) - SUM_W'(buffer[wr_ptr]);
    fill_next = (fill == FILL_FULL) ? fill : fill + (AVG_LOG2+1)'(1);
  end

  // Filter state: circular buffer, running sum, fill count and averaged output
  always_ff @(posedge CLK100MHZ or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++)
        buffer[i] <= '0;
      wr_ptr         <= '0;
      fill           <= '0;
      sum            <= '0;
      filtered       <= '0;
      filtered_valid <= 1'b0;
    end else begin
      filtered_valid <= 1'b0;
      if (decode_valid) begin
        buffer[wr_ptr] <= decode_out;
        wr_ptr         <= wr_ptr + AVG_LOG2'(1);
        sum            <= sum_next;
        fill           <= fill_next;
        filtered       <= WIDTH'(sum_next >>> AVG_LOG2);
        filtered_valid <= (fill_next == FILL_FULL);
      end
    end
  end

  // Busy covers RUN plus any stage still holding a sample; registered so it
  // drops one cycle after the final filter update
  always_ff @(posedge CLK100MHZ or negedge reset) begin
    if (!reset)
      busy <= 1'b0;
    else
      busy <= (state_next == RUN) || s_valid || encoded_valid || decode_valid;
  end

endmodule
